comp_stream_sequencer: RTL and testbench
========================================

Name: comp_stream_sequencer

Overview:
- Job-level controller in front of Compression_Top.
- Pulls a programmed number of 64-bit words from an upstream source (valid/ready) and presents them on the compressor's data_in/data_in_valid/comp_rdy handshake, holding each word until it is accepted.
- Handles pause via the compressor's stall input.
- After the last word, monitors valid_bits until the compressor has drained, then pulses done with word and compressed-bit counts.

Parameters:
- CNT_BITS, 20: width of word_count / words_sent.
- DRAIN_IDLE, 64: consecutive idle compressor-output cycles that declare drain complete.
- DRAIN_TIMEOUT, 20480: maximum cycles spent in DRAIN before forced completion.
- TO_BITS, 16: width of drain counters; must hold DRAIN_TIMEOUT.

Ports:
- clock  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- start  in  1  one-cycle job start; sampled only in IDLE
- word_count  in  CNT_BITS  words in job; sampled with start
- pause  in  1  request to stall the compressor
- src_valid  in  1  upstream word available
- src_data  in  64  upstream word
- src_ready  out  1  sequencer takes src_data this cycle
- comp_rdy  in  1  compressor ready (from Compression_Top)
- comp_dump  in  1  compressor dump indication
- comp_valid_bits  in  8  compressor output bit count this cycle
- stall  out  1  to Compression_Top stall
- data_in_valid  out  1  to Compression_Top
- data_in  out  64  to Compression_Top
- busy  out  1  job in progress
- done  out  1  one-cycle job-complete pulse
- timeout  out  1  drain ended by timeout; sticky until next accepted start
- words_sent  out  CNT_BITS  words accepted by the compressor this job
- bits_out  out  32  sum of comp_valid_bits during the job

Behaviour:
- Reset (async, reset=0) values: state IDLE; stall, data_in_valid, busy, done, timeout = 0; data_in, words_sent, bits_out, remaining, drain counters = 0.
- stall is pause registered (1-cycle latency).
- Transfer: occurs at a posedge where data_in_valid && comp_rdy && !stall.
- Hold rule: data_in is held stable while data_in_valid is high and no transfer occurs; a word presented while comp_rdy is low is never dropped or duplicated.
- src_ready (combinational) = (state==FETCH) || (state==SEND && transfer-condition && remaining!=1).
- Source take: a source word is taken when src_valid && src_ready.
- IDLE:
  - busy=0.
  - start with word_count!=0: latch remaining=word_count, clear words_sent, bits_out and timeout; go to FETCH.
  - start with word_count==0: go to DONE.
- FETCH:
  - busy=1.
  - On a source take, load data_in, set data_in_valid=1, go to SEND; otherwise wait with data_in_valid=0.
- SEND:
  - On transfer: words_sent+1, remaining-1.
  - If remaining was 1: data_in_valid=0, go to DRAIN.
  - Else if a source word is taken in the same cycle: reload data_in and stay in SEND (back-to-back, 1 word/cycle).
  - Else: data_in_valid=0, go to FETCH.
- DRAIN:
  - idle_cnt increments on cycles with comp_valid_bits==0 and !comp_dump; otherwise it clears.
  - to_cnt increments every cycle.
  - idle_cnt==DRAIN_IDLE-1 on an idle cycle: go to DONE.
  - Else if to_cnt==DRAIN_TIMEOUT-1: set timeout=1 and go to DONE. If both hit on the same cycle, the idle exit wins and timeout stays 0.
- DONE: done=1 for exactly one cycle, busy=0, go to IDLE. words_sent and bits_out hold until the next start.
- bits_out: adds the zero-extended comp_valid_bits every cycle the state is not IDLE and not DONE; wraps modulo 2^32.
- start while busy: ignored.
- pause: asserted in any state, it only blocks transfers (through stall); counters keep running in DRAIN.
- Reset mid-job: immediate return to reset values; no done pulse; upstream words already taken are lost.

Test Plan:
- Basic job: word_count=4, src_valid and comp_rdy held high, no pause → src_data W0..W3 appear on consecutive cycles with data_in_valid=1; words_sent=4; with comp_valid_bits=0 after the last word, done pulses DRAIN_IDLE+1 cycles after the last transfer; timeout=0.
- Backpressure: word_count=3, comp_rdy low for 5 cycles while W1 is presented → data_in holds W1 all 5 cycles; W1 is transferred once; sequence W0,W1,W2; words_sent=3.
- Pause: pause=1 for 4 cycles mid-job with comp_rdy=1 → stall rises 1 cycle after pause; no transfers occur while stall=1; the job resumes and completes with the correct word order.
- Drain accounting: comp_valid_bits pattern 5,0,12,0..., with a comp_dump pulse in DRAIN → idle_cnt restarts after each nonzero bit count and after the dump; bits_out=17.
- Timeout: comp_valid_bits held at 1 throughout DRAIN → done pulse after DRAIN_TIMEOUT cycles, timeout=1; next start clears timeout.
- Edges: word_count=0 → done pulse 1 cycle after start with words_sent=0; reset asserted during SEND → all outputs zero immediately; start asserted while busy → ignored.

Source files
------------

// File: rtl/comp_stream_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : comp_stream_sequencer
// Function : Job controller that streams a counted run of 64-bit words into
//            the compressor, then waits for its output to drain.
// Revision : 1.0  initial release
// ============================================================================
module comp_stream_sequencer #(
   parameter int CNT_BITS      = 20,
   parameter int DRAIN_IDLE    = 64,
   parameter int DRAIN_TIMEOUT = 20480,
   parameter int TO_BITS       = 16
) (
   input  logic                clk_i,
   input  logic                rst_ni,
   input  logic                start_i,
   input  logic [CNT_BITS-1:0] word_count_i,
   input  logic                pause_i,
   input  logic                src_valid_i,
   input  logic [63:0]         src_data_i,
   output logic                src_ready_o,
   input  logic                comp_rdy_i,
   input  logic                comp_dump_i,
   input  logic [7:0]          comp_valid_bits_i,
   output logic                stall_o,
   output logic                data_in_valid_o,
   output logic [63:0]         data_in_o,
   output logic                busy_o,
   output logic                done_o,
   output logic                timeout_o,
   output logic [CNT_BITS-1:0] words_sent_o,
   output logic [31:0]         bits_out_o
);

   localparam logic [2:0]          c_ST_IDLE  = 3'd0;
   localparam logic [2:0]          c_ST_FETCH = 3'd1;
   localparam logic [2:0]          c_ST_SEND  = 3'd2;
   localparam logic [2:0]          c_ST_DRAIN = 3'd3;
   localparam logic [2:0]          c_ST_DONE  = 3'd4;
   localparam logic [TO_BITS-1:0]  c_IDLE_LAST = TO_BITS'(DRAIN_IDLE - 1);
   localparam logic [TO_BITS-1:0]  c_TO_LAST   = TO_BITS'(DRAIN_TIMEOUT - 1);
   localparam logic [TO_BITS-1:0]  c_TO_ONE    = TO_BITS'(1);
   localparam logic [CNT_BITS-1:0] c_CNT_ONE   = CNT_BITS'(1);

   logic [2:0]          state_q, state_d;
   logic                stall_q;
   logic                dvalid_q, dvalid_d;
   logic [63:0]         data_q, data_d;
   logic [CNT_BITS-1:0] remaining_q, remaining_d;
   logic [CNT_BITS-1:0] words_q, words_d;
   logic [31:0]         bits_q, bits_d;
   logic                timeout_q, timeout_d;
   logic [TO_BITS-1:0]  idle_cnt_q, idle_cnt_d;
   logic [TO_BITS-1:0]  to_cnt_q, to_cnt_d;

   logic w_xfer;
   logic w_last;
   logic w_take;
   logic w_idle;
   logic w_idle_exit;
   logic w_to_exit;

   assign w_xfer      = dvalid_q & comp_rdy_i & ~stall_q;
   assign w_last      = (remaining_q == c_CNT_ONE);
   assign w_take      = src_valid_i & src_ready_o;
   assign w_idle      = (comp_valid_bits_i == 8'd0) & ~comp_dump_i;
   // The idle-run exit has priority over the timeout when both land together.
   assign w_idle_exit = (state_q == c_ST_DRAIN) & w_idle & (idle_cnt_q == c_IDLE_LAST);
   assign w_to_exit   = (state_q == c_ST_DRAIN) & ~w_idle_exit & (to_cnt_q == c_TO_LAST);

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= c_ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         c_ST_IDLE: begin
            if (start_i) begin
               state_d = (word_count_i != '0) ? c_ST_FETCH : c_ST_DONE;
            end
         end
         c_ST_FETCH: begin
            if (w_take) begin
               state_d = c_ST_SEND;
            end
         end
         c_ST_SEND: begin
            if (w_xfer) begin
               if (w_last) begin
                  state_d = c_ST_DRAIN;
               end else if (!w_take) begin
                  state_d = c_ST_FETCH;
               end
            end
         end
         c_ST_DRAIN: begin
            if (w_idle_exit || w_to_exit) begin
               state_d = c_ST_DONE;
            end
         end
         c_ST_DONE: state_d = c_ST_IDLE;
         default:   state_d = c_ST_IDLE;
      endcase
   end

   always_comb begin
      busy_o      = 1'b0;
      done_o      = 1'b0;
      src_ready_o = 1'b0;
      case (state_q)
         c_ST_FETCH: begin
            busy_o      = 1'b1;
            src_ready_o = 1'b1;
         end
         c_ST_SEND: begin
            busy_o      = 1'b1;
            src_ready_o = w_xfer & ~w_last;
         end
         c_ST_DRAIN: busy_o = 1'b1;
         c_ST_DONE:  done_o = 1'b1;
         default: ;
      endcase
   end

   always_comb begin
      data_d      = data_q;
      dvalid_d    = dvalid_q;
      remaining_d = remaining_q;
      words_d     = words_q;
      bits_d      = bits_q;
      timeout_d   = timeout_q;
      idle_cnt_d  = '0;
      to_cnt_d    = '0;
      if ((state_q != c_ST_IDLE) && (state_q != c_ST_DONE)) begin
         bits_d = bits_q + {24'd0, comp_valid_bits_i};
      end
      case (state_q)
         c_ST_IDLE: begin
            if (start_i) begin
               remaining_d = word_count_i;
               words_d     = '0;
               bits_d      = '0;
               timeout_d   = 1'b0;
            end
         end
         c_ST_FETCH: begin
            if (w_take) begin
               data_d   = src_data_i;
               dvalid_d = 1'b1;
            end
         end
         c_ST_SEND: begin
            if (w_xfer) begin
               words_d     = words_q + c_CNT_ONE;
               remaining_d = remaining_q - c_CNT_ONE;
               if (w_last) begin
                  dvalid_d = 1'b0;
               end else if (w_take) begin
                  data_d = src_data_i;
               end else begin
                  dvalid_d = 1'b0;
               end
            end
         end
         c_ST_DRAIN: begin
            idle_cnt_d = w_idle ? (idle_cnt_q + c_TO_ONE) : '0;
            to_cnt_d   = to_cnt_q + c_TO_ONE;
            if (w_to_exit) begin
               timeout_d = 1'b1;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         stall_q     <= 1'b0;
         dvalid_q    <= 1'b0;
         data_q      <= '0;
         remaining_q <= '0;
         words_q     <= '0;
         bits_q      <= '0;
         timeout_q   <= 1'b0;
         idle_cnt_q  <= '0;
         to_cnt_q    <= '0;
      end else begin
         stall_q     <= pause_i;
         dvalid_q    <= dvalid_d;
         data_q      <= data_d;
         remaining_q <= remaining_d;
         words_q     <= words_d;
         bits_q      <= bits_d;
         timeout_q   <= timeout_d;
         idle_cnt_q  <= idle_cnt_d;
         to_cnt_q    <= to_cnt_d;
      end
   end

   assign stall_o         = stall_q;
   assign data_in_valid_o = dvalid_q;
   assign data_in_o       = data_q;
   assign timeout_o       = timeout_q;
   assign words_sent_o    = words_q;
   assign bits_out_o      = bits_q;

endmodule
`default_nettype wire

// File: tb/tb_comp_stream_sequencer.sv
`default_nettype none
// Bench for comp_stream_sequencer: job-level reference model compared every
// cycle, directed scenarios with literal expectations, then random jobs.
module tb_comp_stream_sequencer;

   localparam int          CNT_BITS      = 20;
   localparam int          DRAIN_IDLE    = 64;
   localparam int          DRAIN_TIMEOUT = 20480;
   localparam logic [63:0] SEQ_BASE      = 64'hC0DE_0000_0000_0000;

   logic                clk        = 1'b0;
   logic                rst_n      = 1'b0;
   logic                start      = 1'b0;
   logic [CNT_BITS-1:0] wc         = '0;
   logic                pause      = 1'b0;
   logic                src_valid  = 1'b0;
   logic [63:0]         src_data   = '0;
   logic                comp_rdy   = 1'b0;
   logic                comp_dump  = 1'b0;
   logic [7:0]          vb         = '0;
   logic                src_ready, stall, dvalid, busy, done, timeout;
   logic [63:0]         data_in;
   logic [CNT_BITS-1:0] words_sent;
   logic [31:0]         bits_out;

   comp_stream_sequencer #(
      .CNT_BITS(CNT_BITS), .DRAIN_IDLE(DRAIN_IDLE),
      .DRAIN_TIMEOUT(DRAIN_TIMEOUT), .TO_BITS(16)
   ) dut (
      .clk_i(clk), .rst_ni(rst_n), .start_i(start), .word_count_i(wc),
      .pause_i(pause), .src_valid_i(src_valid), .src_data_i(src_data),
      .src_ready_o(src_ready), .comp_rdy_i(comp_rdy), .comp_dump_i(comp_dump),
      .comp_valid_bits_i(vb), .stall_o(stall), .data_in_valid_o(dvalid),
      .data_in_o(data_in), .busy_o(busy), .done_o(done), .timeout_o(timeout),
      .words_sent_o(words_sent), .bits_out_o(bits_out)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Job-level model: 0 idle, 1 moving words, 2 draining, 3 done pulse.
   int          m_mode, m_to_fetch, m_sent, m_run, m_elapsed;
   bit          m_held, m_timeout, m_stall, m_took;
   logic [63:0] m_word;
   logic [31:0] m_bits;

   logic [63:0] xfers[$];
   int  cyc = 0, first_xfer_cyc, last_xfer_cyc, done_cyc, start_cyc, stall_cnt;
   bit  done_seen, seq_mode;
   int  seq_k;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic bit m_xfer();
      return (m_mode == 1) && m_held && comp_rdy && !m_stall;
   endfunction

   function automatic bit m_src_ready();
      return (m_mode == 1) && (m_to_fetch > 0) && (!m_held || m_xfer());
   endfunction

   function automatic logic [63:0] xfer_at(input int i);
      if (i < xfers.size()) return xfers[i];
      return '1;
   endfunction

   task automatic model_reset();
      m_mode = 0; m_to_fetch = 0; m_sent = 0; m_run = 0; m_elapsed = 0;
      m_held = 0; m_timeout = 0; m_stall = 0; m_took = 0;
      m_word = '0; m_bits = '0;
   endtask

   task automatic model_step();
      bit x, t, idle;
      x = m_xfer();
      t = src_valid && m_src_ready();
      m_took = 0;
      case (m_mode)
         0: if (start) begin
               m_sent = 0; m_bits = '0; m_timeout = 0;
               m_to_fetch = int'(wc);
               m_mode = (wc == '0) ? 3 : 1;
            end
         1: begin
               m_bits += {24'd0, vb};
               if (x) m_sent++;
               m_held = (m_held && !x) || t;
               if (t) begin
                  m_word = src_data; m_to_fetch--; m_took = 1;
               end
               if (x && !m_held && m_to_fetch == 0) begin
                  m_mode = 2; m_run = 0; m_elapsed = 0;
               end
            end
         2: begin
               m_bits += {24'd0, vb};
               m_elapsed++;
               idle = (vb == 8'd0) && !comp_dump;
               m_run = idle ? m_run + 1 : 0;
               if (idle && m_run == DRAIN_IDLE) m_mode = 3;
               else if (m_elapsed == DRAIN_TIMEOUT) begin
                  m_timeout = 1; m_mode = 3;
               end
            end
         default: m_mode = 0;
      endcase
      m_stall = pause;
   endtask

   task automatic compare();
      chk("stall", 64'(stall), 64'(m_stall));
      chk("busy", 64'(busy), 64'(m_mode == 1 || m_mode == 2));
      chk("done", 64'(done), 64'(m_mode == 3));
      chk("data_in_valid", 64'(dvalid), 64'(m_mode == 1 && m_held));
      if (m_mode == 1 && m_held) chk("data_in", data_in, m_word);
      chk("src_ready", 64'(src_ready), 64'(m_src_ready()));
      chk("words_sent", 64'(words_sent), 64'(m_sent));
      chk("bits_out", 64'(bits_out), 64'(m_bits));
      chk("timeout", 64'(timeout), 64'(m_timeout));
   endtask

   task automatic tick();
      @(negedge clk);
      compare();
      if (rst_n && dvalid && comp_rdy && !stall) begin
         if (xfers.size() == 0) first_xfer_cyc = cyc;
         xfers.push_back(data_in);
         last_xfer_cyc = cyc;
      end
      if (done) begin
         done_seen = 1; done_cyc = cyc;
      end
      if (stall) stall_cnt++;
      @(posedge clk);
      if (!rst_n) model_reset();
      else model_step();
      #1;
      if (seq_mode && m_took) begin
         seq_k++;
         src_data = SEQ_BASE + 64'(seq_k);
      end
      cyc++;
   endtask

   task automatic new_job(input logic [CNT_BITS-1:0] n);
      xfers.delete();
      done_seen = 0; stall_cnt = 0; seq_k = 0;
      if (seq_mode) src_data = SEQ_BASE;
      start = 1'b1; wc = n; start_cyc = cyc;
      tick();
      start = 1'b0;
   endtask

   task automatic wait_done(input int budget);
      int n = 0;
      while (!done_seen && n < budget) begin
         tick(); n++;
      end
      chk("done_within_budget", 64'(done_seen), 64'd1);
   endtask

   task automatic wait_xfers(input int cnt, input int budget);
      int n = 0;
      while (xfers.size() < cnt && n < budget) begin
         tick(); n++;
      end
      chk("xfers_within_budget", 64'(xfers.size() >= cnt), 64'd1);
   endtask

   task automatic drive_random();
      src_valid = ($urandom_range(0, 3) != 0);
      comp_rdy  = ($urandom_range(0, 3) != 0);
      pause     = ($urandom_range(0, 7) == 0);
      src_data  = {$urandom, $urandom};
      wc        = CNT_BITS'($urandom_range(0, 12));
      if (m_mode == 2) begin
         vb        = ($urandom_range(0, 255) == 0) ? 8'($urandom_range(1, 255)) : 8'd0;
         comp_dump = ($urandom_range(0, 511) == 0);
      end else begin
         vb        = ($urandom_range(0, 1) == 0) ? 8'd0 : 8'($urandom);
         comp_dump = ($urandom_range(0, 63) == 0);
      end
      start = (m_mode == 1 || m_mode == 2) && ($urandom_range(0, 15) == 0);
   endtask

   initial begin
      int bp, hold_cnt, n;
      model_reset();
      repeat (3) tick();
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_done", 64'(done), 64'd0);
      chk("rst_dvalid", 64'(dvalid), 64'd0);
      chk("rst_data_in", data_in, 64'd0);
      chk("rst_words_sent", 64'(words_sent), 64'd0);
      chk("rst_bits_out", 64'(bits_out), 64'd0);
      chk("rst_timeout", 64'(timeout), 64'd0);
      rst_n = 1'b1;
      repeat (2) tick();

      // Basic back-to-back job of four words.
      seq_mode = 1; src_valid = 1; comp_rdy = 1;
      new_job(CNT_BITS'(4));
      wait_done(300);
      chk("basic_count", 64'(xfers.size()), 64'd4);
      for (int i = 0; i < 4; i++) chk("basic_word", xfer_at(i), SEQ_BASE + 64'(i));
      chk("basic_burst_span", 64'(last_xfer_cyc - first_xfer_cyc), 64'd3);
      chk("basic_words_sent", 64'(words_sent), 64'd4);
      chk("basic_timeout", 64'(timeout), 64'd0);
      chk("basic_done_latency", 64'(done_cyc - last_xfer_cyc), 64'(DRAIN_IDLE + 1));

      // Backpressure on the second word, plus a start while busy.
      new_job(CNT_BITS'(3));
      bp = 0; hold_cnt = 0; n = 0;
      while (!done_seen && n < 400) begin
         if (dvalid && data_in == SEQ_BASE + 64'd1) hold_cnt++;
         if (bp < 5 && dvalid && data_in == SEQ_BASE + 64'd1) begin
            comp_rdy = 0; bp++;
         end else comp_rdy = 1;
         start = (bp == 2 && comp_rdy == 0);
         wc = CNT_BITS'(9);
         tick(); n++;
      end
      start = 0; comp_rdy = 1;
      chk("bp_done", 64'(done_seen), 64'd1);
      chk("bp_count", 64'(xfers.size()), 64'd3);
      for (int i = 0; i < 3; i++) chk("bp_word", xfer_at(i), SEQ_BASE + 64'(i));
      chk("bp_hold_cycles", 64'(hold_cnt), 64'd6);
      chk("bp_words_sent", 64'(words_sent), 64'd3);

      // Pause for four cycles mid-job.
      new_job(CNT_BITS'(6));
      wait_xfers(2, 50);
      pause = 1;
      repeat (4) tick();
      pause = 0;
      wait_done(300);
      chk("pause_stall_cycles", 64'(stall_cnt), 64'd4);
      chk("pause_count", 64'(xfers.size()), 64'd6);
      for (int i = 0; i < 6; i++) chk("pause_word", xfer_at(i), SEQ_BASE + 64'(i));
      chk("pause_words_sent", 64'(words_sent), 64'd6);

      // Drain accounting: 5,0,12 then a dump pulse restart the idle run.
      new_job(CNT_BITS'(1));
      wait_xfers(1, 50);
      n = 1;
      while (!done_seen && n < 400) begin
         vb = (n == 1) ? 8'd5 : (n == 3) ? 8'd12 : 8'd0;
         comp_dump = (n == 6);
         tick(); n++;
      end
      vb = 0; comp_dump = 0;
      chk("drain_done", 64'(done_seen), 64'd1);
      chk("drain_bits_out", 64'(bits_out), 64'd17);
      chk("drain_done_latency", 64'(done_cyc - last_xfer_cyc), 64'd71);
      chk("drain_timeout", 64'(timeout), 64'd0);

      // Drain never goes quiet: forced completion.
      vb = 8'd1;
      new_job(CNT_BITS'(1));
      wait_done(DRAIN_TIMEOUT + 200);
      vb = 8'd0;
      chk("to_timeout", 64'(timeout), 64'd1);
      chk("to_bits_out", 64'(bits_out), 64'(DRAIN_TIMEOUT + 2));
      chk("to_done_latency", 64'(done_cyc - last_xfer_cyc), 64'(DRAIN_TIMEOUT + 1));

      // Zero-length job; it also clears the sticky timeout.
      new_job(CNT_BITS'(0));
      wait_done(10);
      chk("zero_done_latency", 64'(done_cyc - start_cyc), 64'd1);
      chk("zero_timeout_cleared", 64'(timeout), 64'd0);
      chk("zero_words_sent", 64'(words_sent), 64'd0);

      // Reset while a word is held in SEND.
      vb = 8'd3;
      new_job(CNT_BITS'(5));
      wait_xfers(2, 50);
      pause = 1;
      tick();
      rst_n = 0;
      #1;
      chk("midrst_dvalid", 64'(dvalid), 64'd0);
      chk("midrst_data_in", data_in, 64'd0);
      chk("midrst_busy", 64'(busy), 64'd0);
      chk("midrst_words_sent", 64'(words_sent), 64'd0);
      chk("midrst_bits_out", 64'(bits_out), 64'd0);
      chk("midrst_stall", 64'(stall), 64'd0);
      chk("midrst_src_ready", 64'(src_ready), 64'd0);
      model_reset();
      pause = 0; vb = 0;
      repeat (2) tick();
      rst_n = 1;
      tick();

      // Random jobs against the model.
      seq_mode = 0;
      for (int j = 0; j < 40; j++) begin
         repeat ($urandom_range(0, 3)) begin
            drive_random(); tick();
         end
         drive_random();
         new_job(CNT_BITS'($urandom_range(0, 12)));
         n = 0;
         while (!done_seen && n < 3000) begin
            drive_random(); tick(); n++;
         end
         start = 0;
         chk("rand_job_done", 64'(done_seen), 64'd1);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
